// File: rtl/program_counter_rs.sv
// Program counter with a hardware return-address stack: sequential/stalled fetch, jump, relative branch, call, return.
// Optional sticky stack-error output enabled by defining PC_STACK_ERR_EN.
module program_counter_rs #(
  parameter int                ADDR_W      = 12,
  parameter int                OFF_W       = 8,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_no_inc,
  input  logic                               i_jmp,
  input  logic [ADDR_W-1:0]                  i_jmp_addr,
  input  logic                               i_br,
  input  logic [OFF_W-1:0]                   i_br_off,
  input  logic                               i_call,
  input  logic                               i_ret,
  output logic [ADDR_W-1:0]                  o_addr_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   o_stk_level,
  output logic                               o_stk_full,
  output logic                               o_stk_empty
`ifdef PC_STACK_ERR_EN
  ,output logic                              o_stk_err
`endif
);

  localparam int                LVL_W    = $clog2(STACK_DEPTH + 1);
  localparam int                IDX_W    = $clog2(STACK_DEPTH);
  localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(STACK_DEPTH);

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
  logic [LVL_W-1:0]  r_level;

  logic              w_empty;
  logic              w_full;
  logic              w_ret_ok;
  logic              w_call_ok;
  logic [IDX_W-1:0]  w_top_idx;
  logic [IDX_W-1:0]  w_push_idx;
  logic [ADDR_W-1:0] w_top;
  logic [ADDR_W-1:0] w_addr_inc;
  logic [ADDR_W-1:0] w_off_ext;
  logic [ADDR_W-1:0] w_addr_nxt;

  assign w_empty    = (r_level == '0);
  assign w_full     = (r_level == LVL_FULL);
  // A return on an empty stack is dropped so lower-priority controls still act.
  assign w_ret_ok   = i_ret && !w_empty;
  assign w_call_ok  = i_call && !w_ret_ok;
  assign w_top_idx  = IDX_W'(r_level - LVL_W'(1));
  assign w_push_idx = w_full ? IDX_W'(STACK_DEPTH - 1) : IDX_W'(r_level);
  assign w_top      = r_stack[w_top_idx];
  assign w_addr_inc = r_addr + ADDR_W'(1);
  assign w_off_ext  = ADDR_W'($signed(i_br_off));

  always_comb begin
    w_addr_nxt = r_addr;
    if (w_ret_ok)
      w_addr_nxt = w_top;
    else if (i_call || i_jmp)
      w_addr_nxt = i_jmp_addr;
    else if (i_br)
      w_addr_nxt = r_addr + w_off_ext;
    else if (!i_no_inc)
      w_addr_nxt = w_addr_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_addr <= RESET_ADDR;
    else
      r_addr <= w_addr_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_level <= '0;
    else if (w_ret_ok)
      r_level <= r_level - LVL_W'(1);
    else if (w_call_ok && !w_full)
      r_level <= r_level + LVL_W'(1);
  end

  // On overflow the oldest entry (index 0) falls off and the new one lands on top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STACK_DEPTH; i++)
        r_stack[i] <= '0;
    end else if (w_call_ok) begin
      if (w_full) begin
        for (int i = 0; i < STACK_DEPTH - 1; i++)
          r_stack[i] <= r_stack[i+1];
      end
      r_stack[w_push_idx] <= w_addr_inc;
    end
  end

`ifdef PC_STACK_ERR_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err <= 1'b0;
    else if ((i_ret && w_empty) || (w_call_ok && w_full))
      r_err <= 1'b1;
  end

  assign o_stk_err = r_err;
`endif

  assign o_addr_out  = r_addr;
  assign o_stk_level = r_level;
  assign o_stk_full  = w_full;
  assign o_stk_empty = w_empty;

endmodule
